// File: rtl/edge_event_arbiter_if.sv
// Valid/ready event bus carrying the granted channel number to the consumer.
interface edge_event_arbiter_if #(
  parameter int unsigned IDXW = 2
);
  logic            evt_valid;
  logic [IDXW-1:0] evt_idx;
  logic            evt_ready;

  modport master (output evt_valid, output evt_idx, input evt_ready);
  modport slave  (input evt_valid, input evt_idx, output evt_ready);
endinterface

// File: rtl/edge_event_arbiter.sv
// Synchronises N async inputs, latches enabled rising edges and serialises them round-robin.
// Optional sticky lost-event flags are built when EDGE_ARB_OVERRUN_EN is defined.
module edge_event_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned IDXW        = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         in,
  input  logic [N-1:0]         en,
  edge_event_arbiter_if.master evt,
  output logic [N-1:0]         pending,
  output logic [N-1:0]         overrun,
  input  logic [N-1:0]         ovr_clr
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t               state;
  logic [N-1:0]         sync_q [SYNC_STAGES];
  logic [N-1:0]         hist;
  logic [SYNC_STAGES:0] arm_sr;
  logic                 armed;
  logic [IDXW-1:0]      ptr;
  logic [IDXW-1:0]      idx_q;
  logic [IDXW-1:0]      grant_idx;
  logic [N-1:0]         rise;
  logic [N-1:0]         grant_mask;
  logic                 found;
  logic                 load;
  int                   cand;

  assign armed = arm_sr[SYNC_STAGES];
  assign rise  = sync_q[SYNC_STAGES-1] & ~hist & en & {N{armed}};

  // Synchroniser, history flop and arming delay; arming waits until the pipe holds real samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= '0;
      hist   <= '0;
      arm_sr <= '0;
    end else begin
      sync_q[0] <= in;
      for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
      hist   <= sync_q[SYNC_STAGES-1];
      arm_sr <= {arm_sr[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // First pending channel at or above ptr, wrapping
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < int'(N); k++) begin
      cand = int'(ptr) + k;
      if (cand >= int'(N)) cand = cand - int'(N);
      if (!found && pending[cand[PW-1:0]]) begin
        found     = 1'b1;
        grant_idx = IDXW'(cand);
      end
    end
  end

  assign load       = found && ((state == IDLE) || evt.evt_ready);
  assign grant_mask = load ? (N'(1) << grant_idx) : '0;

  // Output FSM, pointer and pending flags; a same-edge rise re-arms the granted channel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idx_q   <= '0;
      ptr     <= '0;
      pending <= '0;
    end else begin
      pending <= (pending & ~grant_mask) | rise;
      if (load) begin
        state <= HOLD;
        idx_q <= grant_idx;
        ptr   <= (grant_idx == IDXW'(N - 1)) ? '0 : grant_idx + IDXW'(1);
      end else if ((state == HOLD) && evt.evt_ready) begin
        state <= IDLE;
      end
    end
  end

  assign evt.evt_valid = (state == HOLD);
  assign evt.evt_idx   = idx_q;

`ifdef EDGE_ARB_OVERRUN_EN
  // Lost edge: new rise while the channel is still pending and not granted this edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overrun <= '0;
    else        overrun <= (overrun & ~ovr_clr) | (rise & pending & ~grant_mask);
  end
`else
  logic unused_ovr_clr;
  assign unused_ovr_clr = ^ovr_clr;
  assign overrun        = '0;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: directed scenarios plus randomized traffic
// compared every cycle against an event-level reference model.
module tb_edge_event_arbiter;

  localparam int N    = 4;
  localparam int IDXW = 2;
  localparam int SS   = 2;
`ifdef EDGE_ARB_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] in_v;
  logic [N-1:0] en_v;
  logic [N-1:0] clr_v;
  logic [N-1:0] pend_w;
  logic [N-1:0] ovr_w;

  edge_event_arbiter_if #(.IDXW(IDXW)) bus ();

  edge_event_arbiter #(.N(N), .IDXW(IDXW), .SYNC_STAGES(SS)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in_v),
    .en      (en_v),
    .evt     (bus),
    .pending (pend_w),
    .overrun (ovr_w),
    .ovr_clr (clr_v)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: edges since reset release and the sample seen at each edge
  int           edge_k;
  logic [N-1:0] hist_q [$];
  logic         m_valid;
  logic [1:0]   m_idx;
  int           m_ptr;
  logic [N-1:0] m_pend;
  logic [N-1:0] m_ovr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] samp(input int k);
    if (k < 1 || k > hist_q.size()) return '0;
    return hist_q[k-1];
  endfunction

  task automatic model_clear();
    edge_k  = 0;
    hist_q.delete();
    m_valid = 1'b0;
    m_idx   = 2'd0;
    m_ptr   = 0;
    m_pend  = '0;
    m_ovr   = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] s, h, rise, gmask;
    int g;
    if (!reset) begin
      model_clear();
      return;
    end
    s     = samp(edge_k - SS + 1);
    h     = samp(edge_k - SS);
    rise  = (edge_k >= SS + 1) ? (s & ~h & en_v) : '0;
    gmask = '0;
    if (m_pend != '0 && (!m_valid || bus.evt_ready)) begin
      g = -1;
      for (int j = 0; j < N; j++)
        if (g < 0 && m_pend[(m_ptr + j) % N]) g = (m_ptr + j) % N;
      gmask[g] = 1'b1;
      m_idx    = 2'(g);
      m_ptr    = (g + 1) % N;
      m_valid  = 1'b1;
    end else if (m_valid && bus.evt_ready) begin
      m_valid = 1'b0;
    end
`ifdef EDGE_ARB_OVERRUN_EN
    m_ovr = (m_ovr & ~clr_v) | (rise & m_pend & ~gmask);
`endif
    m_pend = (m_pend & ~gmask) | rise;
    edge_k++;
    hist_q.push_back(in_v);
  endtask

  task automatic compare();
    check("evt_valid", 32'(bus.evt_valid), 32'(m_valid));
    check("evt_idx",   32'(bus.evt_idx),   32'(m_idx));
    check("pending",   32'(pend_w),        32'(m_pend));
    check("overrun",   32'(ovr_w),         32'(m_ovr));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Called just after a falling clock edge; returns at a falling edge with reset released
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_valid",   32'(bus.evt_valid), 32'd0);
    check("rst_idx",     32'(bus.evt_idx),   32'd0);
    check("rst_pending", 32'(pend_w),        32'd0);
    check("rst_overrun", 32'(ovr_w),         32'd0);
    model_clear();
    compare();
    run(2);
    reset = 1'b1;
  endtask

  initial begin
    in_v = '0; en_v = '0; clr_v = '0; bus.evt_ready = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Single event on channel 2
    en_v = 4'b0100;
    run(5);
    in_v = 4'b0100;
    run(3);
    check("single_pend_t2",  32'(pend_w),        32'h4);
    check("single_valid_t2", 32'(bus.evt_valid), 32'd0);
    run(1);
    check("single_valid_t3", 32'(bus.evt_valid), 32'd1);
    check("single_idx_t3",   32'(bus.evt_idx),   32'd2);
    bus.evt_ready = 1'b1;
    run(1);
    check("single_drop", 32'(bus.evt_valid), 32'd0);
    bus.evt_ready = 1'b0;
    run(5);
    check("single_once", 32'({pend_w, bus.evt_valid}), 32'd0);
    in_v = '0;
    run(3);

    // Disabled channels
    en_v = '0;
    for (int r = 0; r < 3; r++) begin
      in_v = 4'hF; run(2);
      in_v = 4'h0; run(2);
    end
    check("dis_pending", 32'(pend_w),        32'd0);
    check("dis_valid",   32'(bus.evt_valid), 32'd0);

    // Round robin from ptr=0
    do_reset();
    run(5);
    en_v = 4'hF;
    in_v = 4'hF;
    run(3);
    check("rr0_pend", 32'(pend_w), 32'hF);
    run(1);
    check("rr0_idx0", 32'(bus.evt_idx), 32'd0);
    check("rr0_pendE", 32'(pend_w), 32'hE);
    bus.evt_ready = 1'b1;
    run(1); check("rr0_idx1", 32'(bus.evt_idx), 32'd1);
    run(1); check("rr0_idx2", 32'(bus.evt_idx), 32'd2);
    run(1); check("rr0_idx3", 32'(bus.evt_idx), 32'd3);
    check("rr0_v3", 32'(bus.evt_valid), 32'd1);
    run(1); check("rr0_idle", 32'(bus.evt_valid), 32'd0);
    bus.evt_ready = 1'b0;
    in_v = '0;
    run(3);

    // Round robin from ptr=2 (after a single grant to channel 1)
    in_v = 4'b0010;
    run(4);
    check("rr2_pre_idx", 32'(bus.evt_idx), 32'd1);
    bus.evt_ready = 1'b1;
    run(1);
    bus.evt_ready = 1'b0;
    in_v = '0;
    run(3);
    in_v = 4'hF;
    run(4);
    check("rr2_idx2", 32'(bus.evt_idx), 32'd2);
    bus.evt_ready = 1'b1;
    run(1); check("rr2_idx3", 32'(bus.evt_idx), 32'd3);
    run(1); check("rr2_idx0", 32'(bus.evt_idx), 32'd0);
    run(1); check("rr2_idx1", 32'(bus.evt_idx), 32'd1);
    run(1); check("rr2_idle", 32'(bus.evt_valid), 32'd0);
    bus.evt_ready = 1'b0;
    in_v = '0;
    run(3);

    // Input held high through reset
    in_v = 4'b0010;
    do_reset();
    run(8);
    check("held_noevt", 32'({pend_w, bus.evt_valid}), 32'd0);
    in_v = '0;
    run(3);
    in_v = 4'b0010;
    run(3);
    check("held_pend", 32'(pend_w), 32'h2);
    run(1);
    check("held_valid", 32'(bus.evt_valid), 32'd1);
    check("held_idx",   32'(bus.evt_idx),   32'd1);
    bus.evt_ready = 1'b1;
    run(1);
    bus.evt_ready = 1'b0;
    run(4);
    check("held_once", 32'({pend_w, bus.evt_valid}), 32'd0);
    in_v = '0;
    run(3);

    // Overrun: first edge goes to the output, second pends, third is lost
    for (int r = 0; r < 3; r++) begin
      in_v = 4'b1000; run(2);
      in_v = 4'b0000; run(2);
    end
    run(3);
    check("ovr_pend3", 32'(pend_w[3]), 32'd1);
    check("ovr_set3",  32'(ovr_w[3]),  32'(OVR_EXP));
    clr_v = 4'b1000;
    run(1);
    clr_v = '0;
    check("ovr_clr3", 32'(ovr_w), 32'd0);
    bus.evt_ready = 1'b1;
    run(3);
    bus.evt_ready = 1'b0;
    check("ovr_drain", 32'({pend_w, bus.evt_valid}), 32'd0);

    // Reset while an event is presented and another is pending
    in_v = 4'b0011;
    run(4);
    check("mid_valid", 32'(bus.evt_valid), 32'd1);
    check("mid_pend",  32'(pend_w),        32'h2);
    do_reset();
    in_v = '0;
    run(4);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      logic [N-1:0] flip;
      for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 3) == 0);
      in_v = in_v ^ flip;
      if ($urandom_range(0, 15) == 0) en_v = N'($urandom);
      else if ($urandom_range(0, 31) == 0) en_v = 4'hF;
      bus.evt_ready = ($urandom_range(0, 2) != 0) ^ (c[7] & ($urandom_range(0, 1) == 0));
      clr_v = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 499) == 0) do_reset();
      run(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
